// File: rtl/i_axi_read_bridge_if.sv
// Bus bundle around the icache read bridge: the sram-like miss port plus the AXI read channels.
// The master view belongs to the bridge; the slave view belongs to the cache and memory around it.
interface i_axi_read_bridge_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/i_axi_read_bridge.sv
// Single-outstanding bridge: one icache sram-like miss request becomes one single-beat AXI read,
// answered with a one-cycle inst_data_ok pulse; bad responses and timeouts raise sticky flags.
module i_axi_read_bridge #(
  parameter logic [3:0]  AXI_ID  = 4'd0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  i_axi_read_bridge_if.master        bus,
  output logic                       resp_err,
  output logic                       timeout_err
);
  localparam int unsigned     CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, W_AR, W_R} state_t;

  state_t           state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [1:0]       arsize_q, arsize_d;
  logic             arvalid_q, arvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic accept, ar_fire, r_fire, busy, bad_beat;
  logic unused_inputs;

  assign accept   = (state_q == IDLE) & bus.inst_req;
  assign ar_fire  = arvalid_q & bus.arready;
  assign r_fire   = (state_q == W_R) & bus.rvalid;
  assign busy     = (state_q != IDLE);
  assign bad_beat = (bus.rresp != 2'b00) | (bus.rid != AXI_ID) | ~bus.rlast;
  // Writes are not supported on the fetch path, so inst_wr and inst_wdata are dropped.
  assign unused_inputs = ^{bus.inst_wr, bus.inst_wdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      araddr_q      <= '0;
      arsize_q      <= '0;
      arvalid_q     <= 1'b0;
      cnt_q         <= '0;
      resp_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      araddr_q      <= araddr_d;
      arsize_q      <= arsize_d;
      arvalid_q     <= arvalid_d;
      cnt_q         <= cnt_d;
      resp_err_q    <= resp_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.inst_req) state_d = W_AR;
      W_AR:    if (ar_fire)      state_d = W_R;
      W_R:     if (r_fire)       state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // The wait counter only runs while busy and saturates, so a hung slave raises the flag once.
  always_comb begin
    araddr_d      = araddr_q;
    arsize_d      = arsize_q;
    cnt_d         = cnt_q;
    arvalid_d     = (state_d == W_AR);
    resp_err_d    = resp_err_q | (r_fire & bad_beat);
    timeout_err_d = timeout_err_q;
    if (accept) begin
      araddr_d = bus.inst_addr;
      arsize_d = bus.inst_size;
      cnt_d    = '0;
    end else if (busy && (TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (busy && (TIMEOUT != 0) && (cnt_d == CNT_MAX)) begin
      timeout_err_d = 1'b1;
    end
  end

  always_comb begin
    bus.inst_addr_ok = accept;
    bus.inst_data_ok = r_fire;
    bus.inst_rdata   = bus.rdata;
    bus.arid         = AXI_ID;
    bus.araddr       = araddr_q;
    bus.arlen        = 8'd0;
    bus.arsize       = {1'b0, arsize_q};
    bus.arburst      = 2'b01;
    bus.arlock       = 2'b00;
    bus.arcache      = 4'd0;
    bus.arprot       = 3'd0;
    bus.arvalid      = arvalid_q;
    bus.rready       = (state_q == W_R);
    resp_err         = resp_err_q;
    timeout_err      = timeout_err_q;
  end
endmodule

// File: tb/tb_i_axi_read_bridge.sv
// Randomised scoreboard bench for i_axi_read_bridge: a driver plays cache and AXI slave,
// pushing expected AR/R results; a negedge monitor pops and compares them.
module tb_i_axi_read_bridge;
  localparam logic [3:0] AXI_ID = 4'd0;
  localparam int         TO     = 8;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
  } ar_exp_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
    bit          resp;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic resp_err, timeout_err;

  i_axi_read_bridge_if bus ();

  i_axi_read_bridge #(.AXI_ID(AXI_ID), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .resp_err    (resp_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int      cyc = 0;
  int      errors = 0;
  int      checks = 0;
  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  bit      model_resp = 0;
  int      ar_issued = 0;
  int      ar_count = 0;

  int     entry_cyc, addr_ok_cyc, last_data_ok_cyc;
  bit     txn_active, end_pending, pend_resp, to_sticky, exp_to, b2b_mode;
  r_exp_t r_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic abortRun(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Play one complete read: the cache side issues it, the slave side answers after the given waits.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size, input int ar_wait,
                               input int r_wait, input logic [31:0] data, input logic [1:0] resp,
                               input logic [3:0] id, input logic last, input bit hold_req);
    bit ok;
    if (resp != 2'b00 || id != AXI_ID || !last) model_resp = 1;
    ar_q.push_back('{addr: addr, size: size});
    r_q.push_back('{data: data, lat: ar_wait + r_wait + 2, resp: model_resp});
    ar_issued++;
    bus.inst_req   = 1'b1;
    bus.inst_wr    = 1'($urandom_range(0, 1));
    bus.inst_wdata = $urandom;
    bus.inst_addr  = addr;
    bus.inst_size  = size;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.inst_addr_ok) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) abortRun("addr_ok_wait");
    @(posedge clk); #1;
    if (!hold_req) bus.inst_req = 1'b0;
    repeat (ar_wait) begin @(posedge clk); #1; end
    bus.inst_req = 1'b0;
    bus.arready  = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.arvalid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) abortRun("arvalid_wait");
    @(posedge clk); #1;
    bus.arready = 1'b0;
    repeat (r_wait) begin @(posedge clk); #1; end
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.rresp  = resp;
    bus.rid    = id;
    bus.rlast  = last;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) abortRun("rready_wait");
    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    bus.rdata  = $urandom;
    bus.rresp  = 2'b00;
    bus.rid    = AXI_ID;
    bus.rlast  = 1'b1;
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_arvalid", bus.arvalid, 0);
    checkOutput("rst_rready", bus.rready, 0);
    checkOutput("rst_addr_ok", bus.inst_addr_ok, 0);
    checkOutput("rst_data_ok", bus.inst_data_ok, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_araddr", bus.araddr, 0);
    checkOutput("rst_arsize", bus.arsize, 0);
    model_resp = 0;
    ar_q.delete();
    r_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: timeout_err follows "cycles since W_AR entry >= TO"; other results pop the queues.
  always @(negedge clk) begin
    if (!rst) begin
      to_sticky   = 0;
      txn_active  = 0;
      end_pending = 0;
    end else begin
      exp_to = to_sticky | (txn_active && (cyc - entry_cyc) >= TO);
      checkOutput("timeout_err", timeout_err, exp_to);
      if (end_pending) begin
        checkOutput("resp_err", resp_err, pend_resp);
        to_sticky   = exp_to;
        txn_active  = 0;
        end_pending = 0;
      end
      if (txn_active) checkOutput("addr_ok_while_busy", bus.inst_addr_ok, 0);
      if (bus.arvalid) begin
        if (ar_q.size() == 0) begin
          checkOutput("arvalid_unexpected", bus.arvalid, 0);
        end else begin
          checkOutput("araddr", bus.araddr, ar_q[0].addr);
          checkOutput("arsize", bus.arsize, {1'b0, ar_q[0].size});
          checkOutput("ar_constants",
                      {bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
                      {AXI_ID, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
          if (bus.arready) begin
            void'(ar_q.pop_front());
            ar_count++;
          end
        end
      end
      if (bus.inst_addr_ok) begin
        if (b2b_mode) checkOutput("b2b_addr_ok_cycle", cyc, last_data_ok_cyc + 1);
        addr_ok_cyc = cyc;
        entry_cyc   = cyc + 1;
        txn_active  = 1;
      end
      if (bus.inst_data_ok) begin
        if (r_q.size() == 0) begin
          checkOutput("data_ok_unexpected", bus.inst_data_ok, 0);
        end else begin
          r_e = r_q.pop_front();
          checkOutput("inst_rdata", bus.inst_rdata, r_e.data);
          checkOutput("data_ok_latency", cyc - addr_ok_cyc, r_e.lat);
          checkOutput("addr_ok_with_data_ok", bus.inst_addr_ok, 0);
          pend_resp        = r_e.resp;
          end_pending      = 1;
          last_data_ok_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    abortRun("watchdog");
  end

  initial begin
    logic [1:0] rsp;
    logic [3:0] id;
    rst            = 1'b0;
    b2b_mode       = 0;
    bus.inst_req   = 1'b0;
    bus.inst_wr    = 1'b0;
    bus.inst_size  = 2'd0;
    bus.inst_addr  = 32'd0;
    bus.inst_wdata = 32'd0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rdata      = 32'd0;
    bus.rresp      = 2'b00;
    bus.rid        = AXI_ID;
    bus.rlast      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'hBFC0_0000, 2'd2, 0, 0, 32'h3C08_0001, 2'b00, AXI_ID, 1'b1, 1'b0);
    applyStimulus(32'h0000_1236, 2'd1, 5, 0, 32'hCAFE_F00D, 2'b00, AXI_ID, 1'b1, 1'b1);
    applyStimulus(32'h8000_0040, 2'd2, 1, 1, 32'h1111_2222, 2'b10, AXI_ID, 1'b1, 1'b0);
    applyStimulus(32'h8000_0045, 2'd0, 0, 2, 32'h3333_4444, 2'b00, AXI_ID, 1'b1, 1'b0);
    applyStimulus(32'h9FC0_0100, 2'd2, 0, 7, 32'h5555_6666, 2'b00, AXI_ID, 1'b1, 1'b0);

    bus.rvalid = 1'b1;
    bus.rdata  = $urandom;
    @(negedge clk);
    checkOutput("stray_data_ok", bus.inst_data_ok, 0);
    checkOutput("stray_rready", bus.rready, 0);
    @(posedge clk); #1;
    bus.rvalid = 1'b0;

    doReset();
    applyStimulus(32'h1FC0_0200, 2'd2, 0, 20, 32'h7777_8888, 2'b00, AXI_ID, 1'b1, 1'b0);

    // Abandon a read while the bridge is waiting on the R channel.
    ar_q.push_back('{addr: 32'h2000_0010, size: 2'd3});
    ar_issued++;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h2000_0010;
    bus.inst_size = 2'd3;
    @(negedge clk);
    checkOutput("reset_case_addr_ok", bus.inst_addr_ok, 1);
    @(posedge clk); #1;
    bus.inst_req = 1'b0;
    bus.arready  = 1'b1;
    @(posedge clk); #1;
    bus.arready = 1'b0;
    @(negedge clk);
    checkOutput("reset_case_rready", bus.rready, 1);
    doReset();

    for (int i = 0; i < 4; i++) begin
      b2b_mode = (i > 0);
      applyStimulus(32'h0040_0000 + 32'(i * 4), 2'd2, 0, 0, $urandom, 2'b00, AXI_ID, 1'b1, 1'b0);
    end
    b2b_mode = 0;

    doReset();
    for (int i = 0; i < 40; i++) begin
      rsp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      id  = ($urandom_range(0, 9) == 0) ? (AXI_ID ^ 4'($urandom_range(1, 15))) : AXI_ID;
      applyStimulus($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 6),
                    $urandom, rsp, id, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("ar_queue_drained", ar_q.size(), 0);
    checkOutput("r_queue_drained", r_q.size(), 0);
    checkOutput("ar_handshakes", ar_count, ar_issued);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
